jt900h_busarb: RTL and testbench



---
 rtl/jt900h_busarb.sv | 119 +++++++++++
 tb/tb_jt900h_busarb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt900h_busarb.sv
// jt900h_busarb: shares the external 16-bit memory bus between the CPU and the micro-DMA.
// DMA has priority; a burst limit forces one CPU access after MAXBURST DMA accesses.
module jt900h_busarb #(
    parameter int MAXBURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cen,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    input  logic [1:0]  cpu_we,
    input  logic        cpu_rd,
    output logic [15:0] cpu_din,
    output logic        cpu_busy,
    input  logic        dma_req,
    input  logic [22:0] dma_addr,
    input  logic [15:0] dma_dout,
    input  logic [1:0]  dma_we,
    input  logic        dma_rd,
    output logic [15:0] dma_din,
    output logic        dma_busy,
    output logic        dma_gnt,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic [1:0]  bus_we,
    output logic        bus_rd,
    input  logic [15:0] bus_din,
    input  logic        bus_busy
);
    // state    | meaning
    // OWN_NONE | bus idle; a new request is granted on the next cen cycle
    // OWN_CPU  | CPU access on the bus
    // OWN_DMA  | DMA access on the bus
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] MAXB = 4'(MAXBURST);

    owner_t     r_owner, w_owner_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_dma_gnt;
    logic       w_cpu_stb, w_dma_stb, w_dma_act, w_own_stb, w_done;

    always_comb begin
        w_cpu_stb = cpu_rd | (|cpu_we);
        w_dma_stb = dma_rd | (|dma_we);
        w_dma_act = dma_req & w_dma_stb;
        w_own_stb = 1'b0;
        case (r_owner)
            OWN_CPU: w_own_stb = w_cpu_stb;
            OWN_DMA: w_own_stb = w_dma_stb;
            default: w_own_stb = 1'b0;
        endcase
        w_done = w_own_stb & ~bus_busy;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!dma_req || (w_done && r_owner == OWN_CPU))
            w_cnt_nxt = 4'd0;
        else if (w_done && r_owner == OWN_DMA && w_cpu_stb && r_cnt != 4'hF)
            w_cnt_nxt = r_cnt + 4'd1;
    end

    // Arbitration sees the post-completion count so the limit bites at the handoff edge.
    always_comb begin
        w_owner_nxt = r_owner;
        if (r_owner == OWN_NONE || !w_own_stb || w_done) begin
            if (w_dma_act && w_cpu_stb && w_cnt_nxt >= MAXB)
                w_owner_nxt = OWN_CPU;
            else if (w_dma_act)
                w_owner_nxt = OWN_DMA;
            else if (w_cpu_stb)
                w_owner_nxt = OWN_CPU;
            else
                w_owner_nxt = OWN_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner   <= OWN_NONE;
            r_cnt     <= 4'd0;
            r_dma_gnt <= 1'b0;
        end else if (cen) begin
            r_owner   <= w_owner_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dma_gnt <= (w_owner_nxt == OWN_DMA);
        end
    end

    always_comb begin
        bus_addr = 23'd0;
        bus_dout = 16'd0;
        bus_we   = 2'd0;
        bus_rd   = 1'b0;
        case (r_owner)
            OWN_CPU: begin
                bus_addr = cpu_addr;
                bus_dout = cpu_dout;
                bus_we   = cpu_we;
                bus_rd   = cpu_rd;
            end
            OWN_DMA: begin
                bus_addr = dma_addr;
                bus_dout = dma_dout;
                bus_we   = dma_we;
                bus_rd   = dma_rd;
            end
            default: ;
        endcase
    end

    assign cpu_din  = bus_din;
    assign dma_din  = bus_din;
    assign cpu_busy = w_cpu_stb & ~((r_owner == OWN_CPU) & ~bus_busy);
    assign dma_busy = w_dma_stb & ~((r_owner == OWN_DMA) & ~bus_busy);
    assign dma_gnt  = r_dma_gnt;

endmodule

// File: tb/tb_jt900h_busarb.sv
// Bench for jt900h_busarb: spec-level ownership model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_jt900h_busarb;
    localparam int MAXBURST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic [22:0] cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  cpu_we = '0;
    logic        cpu_rd = 1'b0;
    logic [15:0] cpu_din;
    logic        cpu_busy;
    logic        dma_req = 1'b0;
    logic [22:0] dma_addr = '0;
    logic [15:0] dma_dout = '0;
    logic [1:0]  dma_we = '0;
    logic        dma_rd = 1'b0;
    logic [15:0] dma_din;
    logic        dma_busy;
    logic        dma_gnt;
    logic [22:0] bus_addr;
    logic [15:0] bus_dout;
    logic [1:0]  bus_we;
    logic        bus_rd;
    logic [15:0] bus_din = '0;
    logic        bus_busy = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    jt900h_busarb #(.MAXBURST(MAXBURST)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
        .cpu_din(cpu_din), .cpu_busy(cpu_busy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_we(dma_we),
        .dma_rd(dma_rd), .dma_din(dma_din), .dma_busy(dma_busy), .dma_gnt(dma_gnt),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we), .bus_rd(bus_rd),
        .bus_din(bus_din), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    // Model: owner 0=none 1=cpu 2=dma, plus the burst count.
    int m_owner = 0;
    int m_cnt = 0;

    function automatic int arb_f(bit ca, bit da, int c);
        if (ca && da && c >= MAXBURST) return 1;
        if (da) return 2;
        if (ca) return 1;
        return 0;
    endfunction

    function automatic bit owner_strobing();
        bit cs = cpu_rd | (|cpu_we);
        bit ds = dma_rd | (|dma_we);
        return (m_owner == 1 && cs) || (m_owner == 2 && ds);
    endfunction

    function automatic int next_cnt();
        bit cs = cpu_rd | (|cpu_we);
        bit done = owner_strobing() && !bus_busy;
        if (!dma_req) return 0;
        if (done && m_owner == 1) return 0;
        if (done && m_owner == 2 && cs) return (m_cnt >= 15) ? 15 : m_cnt + 1;
        return m_cnt;
    endfunction

    function automatic int next_owner();
        bit cs = cpu_rd | (|cpu_we);
        bit ds = dma_rd | (|dma_we);
        if (m_owner != 0 && owner_strobing() && bus_busy) return m_owner;
        return arb_f(cs, dma_req && ds, next_cnt());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner <= 0;
            m_cnt   <= 0;
        end else if (cen) begin
            m_owner <= next_owner();
            m_cnt   <= next_cnt();
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle_cmp();
        logic [76:0] got, exp;
        logic [22:0] ea;
        logic [15:0] ed;
        logic [1:0]  ew;
        logic        er, cs, ds, eb_c, eb_d, eg;
        cs = cpu_rd | (|cpu_we);
        ds = dma_rd | (|dma_we);
        ea = '0; ed = '0; ew = '0; er = 1'b0;
        if (m_owner == 1) begin
            ea = cpu_addr; ed = cpu_dout; ew = cpu_we; er = cpu_rd;
        end else if (m_owner == 2) begin
            ea = dma_addr; ed = dma_dout; ew = dma_we; er = dma_rd;
        end
        eb_c = cs && !(m_owner == 1 && !bus_busy);
        eb_d = ds && !(m_owner == 2 && !bus_busy);
        eg   = (m_owner == 2);
        exp = {ea, ed, ew, er, eb_c, eb_d, eg, bus_din, bus_din};
        got = {bus_addr, bus_dout, bus_we, bus_rd, cpu_busy, dma_busy, dma_gnt, cpu_din, dma_din};
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // CPU wants one read, DMA wants six; both start strobing together from idle.
    task automatic run_burst(input bit toggle_cen, input string tag);
        int nd = 0;
        int nc = 0;
        string order = "";
        cpu_addr = 23'h000300;
        dma_addr = 23'h002000;
        bus_busy = 1'b0;
        dma_req = 1'b1; dma_rd = 1'b1; cpu_rd = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (!dma_rd && !cpu_rd) break;
            cen = toggle_cen ? ((cyc % 2) == 0) : 1'b1;
            bus_din = 16'h1000 + 16'(cyc);
            @(negedge clk);
            if (cen && cpu_rd && !cpu_busy) begin order = {order, "C"}; nc++; end
            if (cen && dma_rd && !dma_busy) begin order = {order, "D"}; nd++; end
            step(1);
            if (nc >= 1) cpu_rd = 1'b0;
            if (nd >= 6) begin dma_rd = 1'b0; dma_req = 1'b0; end
            else if (cen && dma_gnt) dma_addr = 23'h002000 + 23'(nd);
        end
        cen = 1'b1;
        chk({tag, "_timeout"}, {30'd0, dma_rd, cpu_rd}, 32'd0);
        n_chk++;
        if (order != "DDDDCDD") begin
            n_err++;
            $display("FAIL %s_order got=%s exp=DDDDCDD", tag, order);
        end
        dma_rd = 1'b0; dma_req = 1'b0; cpu_rd = 1'b0;
        step(2);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                cycle_cmp();
            end
        join_none

        rst_n = 1'b0;
        bus_din = 16'h1234;
        step(2);
        rst_n = 1'b1;
        chk("rst_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("rst_we_rd", {29'd0, bus_we, bus_rd}, 32'd0);
        chk("rst_addr", {9'd0, bus_addr}, 32'd0);

        // CPU read from idle: one wait cycle, then the access is on the bus.
        cpu_addr = 23'h000100; cpu_rd = 1'b1;
        #1;
        chk("t1_c1_busy", {31'd0, cpu_busy}, 32'd1);
        chk("t1_c1_rd", {31'd0, bus_rd}, 32'd0);
        step(1);
        chk("t1_c2_rd", {31'd0, bus_rd}, 32'd1);
        chk("t1_c2_addr", {9'd0, bus_addr}, 32'h000100);
        chk("t1_c2_busy", {31'd0, cpu_busy}, 32'd0);
        chk("t1_c2_din", {16'd0, cpu_din}, 32'h1234);
        step(1);
        cpu_rd = 1'b0;
        step(2);

        run_burst(1'b0, "burst");
        run_burst(1'b1, "burst_cen");

        // DMA holds the bus through wait states; CPU takes over at completion.
        cpu_addr = 23'h000555; dma_addr = 23'h001234;
        bus_busy = 1'b1; dma_req = 1'b1; dma_rd = 1'b1; cpu_rd = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_addr", {9'd0, bus_addr}, 32'h001234);
            chk("t3_hold_cbusy", {31'd0, cpu_busy}, 32'd1);
            chk("t3_hold_gnt", {31'd0, dma_gnt}, 32'd1);
            step(1);
        end
        bus_busy = 1'b0; dma_req = 1'b0;
        #1;
        chk("t3_done_addr", {9'd0, bus_addr}, 32'h001234);
        chk("t3_done_dbusy", {31'd0, dma_busy}, 32'd0);
        step(1);
        dma_rd = 1'b0;
        chk("t3_hand_addr", {9'd0, bus_addr}, 32'h000555);
        chk("t3_hand_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("t3_hand_cbusy", {31'd0, cpu_busy}, 32'd0);
        cpu_rd = 1'b0;
        step(2);

        // DMA abandons without completing: CPU waiting takes the bus.
        bus_busy = 1'b1; dma_req = 1'b1; dma_rd = 1'b1; cpu_rd = 1'b1;
        step(1);
        chk("t4_dma_gnt", {31'd0, dma_gnt}, 32'd1);
        dma_req = 1'b0; dma_rd = 1'b0;
        step(1);
        chk("t4_cpu_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("t4_cpu_addr", {9'd0, bus_addr}, 32'h000555);
        chk("t4_cpu_rd", {31'd0, bus_rd}, 32'd1);
        cpu_rd = 1'b0;
        step(1);
        // Same with nobody waiting: bus returns to idle.
        dma_req = 1'b1; dma_rd = 1'b1;
        step(1);
        dma_req = 1'b0; dma_rd = 1'b0;
        step(1);
        chk("t4_none_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("t4_none_addr", {9'd0, bus_addr}, 32'd0);
        bus_busy = 1'b0;
        step(1);

        // Reset in the middle of a DMA write.
        bus_busy = 1'b1; dma_req = 1'b1; dma_we = 2'b11;
        dma_dout = 16'hBEEF; dma_addr = 23'h7ABCD;
        step(1);
        chk("t6_pre_we", {30'd0, bus_we}, 32'd3);
        chk("t6_pre_dout", {16'd0, bus_dout}, 32'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", {30'd0, bus_we}, 32'd0);
        chk("t6_rst_gnt", {31'd0, dma_gnt}, 32'd0);
        chk("t6_rst_addr", {9'd0, bus_addr}, 32'd0);
        chk("t6_rst_dbusy", {31'd0, dma_busy}, 32'd1);
        step(1);
        dma_req = 1'b0; dma_we = 2'b00; bus_busy = 1'b0;
        rst_n = 1'b1;
        step(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
